// File: rtl/sram_arb_pkg.sv
// Shared SRAM geometry, request/response types and helpers for the sky130 1rw1r
// 32x1024 arbiter slice.
package sram_arb_pkg;

   localparam int SRAM_ADDR_WIDTH = 10;
   localparam int SRAM_DATA_WIDTH = 32;
   localparam int SRAM_NUM_WMASKS = 4;
   localparam int SRAM_DEPTH      = 1024;
   localparam int MAX_REQ         = 4;
   localparam int MAX_ID_WIDTH    = 2;

   typedef struct packed {
      logic                       we;
      logic [SRAM_ADDR_WIDTH-1:0] addr;
      logic [SRAM_NUM_WMASKS-1:0] wmask;
      logic [SRAM_DATA_WIDTH-1:0] wdata;
   } sram_req_t;

   typedef struct packed {
      logic [MAX_ID_WIDTH-1:0]    id;
      logic [SRAM_DATA_WIDTH-1:0] data;
   } sram_rsp_t;

   // Index width that stays at least one bit wide for a single requester.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after the pointer,
// wrapping modulo NUM_REQ.
module rr_arbiter
   import sram_arb_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IDW     = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDW-1:0]     ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     winner,
   output logic               any
);

   always_comb begin
      int idx;
      idx    = 0;
      grant  = '0;
      winner = '0;
      any    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (!any && valid[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            winner     = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/sram_rw_arbiter.sv
// Shares the RW port of a 1rw1r OpenRAM macro between NUM_REQ requesters and
// forwards one read-only client to the R port. Optional: SRAM_ARB_COLLISION_STALL_EN.
module sram_rw_arbiter
   import sram_arb_pkg::*;
#(
   parameter  int NUM_REQ    = 2,
   parameter  int ADDR_WIDTH = SRAM_ADDR_WIDTH,
   parameter  int DATA_WIDTH = SRAM_DATA_WIDTH,
   parameter  int NUM_WMASKS = SRAM_NUM_WMASKS,
   localparam int IDW        = id_width(NUM_REQ)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ-1:0]               req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*NUM_WMASKS-1:0]    req_wmask,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   output logic                             rsp_valid,
   output logic [IDW-1:0]                   rsp_id,
   output logic [DATA_WIDTH-1:0]            rsp_data,
   input  logic                             rd_valid,
   output logic                             rd_ready,
   input  logic [ADDR_WIDTH-1:0]            rd_addr,
   output logic                             rd_rsp_valid,
   output logic [DATA_WIDTH-1:0]            rd_rsp_data,
   output logic                             sram_csb0,
   output logic                             sram_web0,
   output logic [NUM_WMASKS-1:0]            sram_wmask0,
   output logic [ADDR_WIDTH-1:0]            sram_addr0,
   output logic [DATA_WIDTH-1:0]            sram_din0,
   input  logic [DATA_WIDTH-1:0]            sram_dout0,
   output logic                             sram_csb1,
   output logic [ADDR_WIDTH-1:0]            sram_addr1,
   input  logic [DATA_WIDTH-1:0]            sram_dout1
);

   logic [IDW-1:0]        ptr;
   logic [IDW-1:0]        ptr_next;
   logic [IDW-1:0]        winner;
   logic [NUM_REQ-1:0]    grant;
   logic                  any_valid;
   logic                  accept;
   logic                  win_we;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [NUM_WMASKS-1:0] win_wmask;
   logic [DATA_WIDTH-1:0] win_wdata;
   logic                  rsp_pending;
   logic [IDW-1:0]        rsp_id_q;
   logic                  rd_pending;
   logic                  rd_accept;
   logic                  collision;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .valid  (req_valid),
      .ptr    (ptr),
      .grant  (grant),
      .winner (winner),
      .any    (any_valid)
   );

   assign accept    = any_valid & ~rst;
   assign req_ready = rst ? '0 : grant;
   assign win_we    = req_we[winner];
   assign win_addr  = req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
   assign win_wmask = req_wmask[winner*NUM_WMASKS +: NUM_WMASKS];
   assign win_wdata = req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];

   // Reads enable every byte lane so the macro never sees a partial read mask.
   always_comb begin
      sram_csb0   = 1'b1;
      sram_web0   = 1'b1;
      sram_wmask0 = '0;
      sram_addr0  = win_addr;
      sram_din0   = win_wdata;
      if (accept) begin
         sram_csb0   = 1'b0;
         sram_web0   = ~win_we;
         sram_wmask0 = win_we ? win_wmask : '1;
      end
   end

   always_comb begin
      ptr_next = winner + 1'b1;
      if (int'(winner) == NUM_REQ - 1) begin
         ptr_next = '0;
      end
   end

`ifdef SRAM_ARB_COLLISION_STALL_EN
   assign collision = accept & win_we & rd_valid & (win_addr == rd_addr);
`else
   assign collision = 1'b0;
`endif

   assign rd_ready   = ~rst & ~collision;
   assign rd_accept  = rd_valid & rd_ready;
   assign sram_csb1  = ~rd_accept;
   assign sram_addr1 = rd_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr         <= '0;
         rsp_pending <= 1'b0;
         rsp_id_q    <= '0;
         rd_pending  <= 1'b0;
      end else begin
         if (accept) begin
            ptr <= ptr_next;
         end
         rsp_pending <= accept & ~win_we;
         if (accept && !win_we) begin
            rsp_id_q <= winner;
         end
         rd_pending <= rd_accept;
      end
   end

   // Gating with rst drops a response whose read was accepted just before reset.
   assign rsp_valid    = rsp_pending & ~rst;
   assign rsp_id       = rst ? '0 : rsp_id_q;
   assign rsp_data     = sram_dout0;
   assign rd_rsp_valid = rd_pending & ~rst;
   assign rd_rsp_data  = sram_dout1;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Scoreboard bench for sram_rw_arbiter with a behavioural 1rw1r macro model.
// Exercises SRAM_ARB_COLLISION_STALL_EN when the macro is defined.
module tb_sram_rw_arbiter;

   localparam int NR  = 2;
   localparam int AW  = 10;
   localparam int DW  = 32;
   localparam int MW  = 4;
   localparam int IDW = 1;

   typedef struct {
      int          id;
      logic [31:0] data;
      int          due;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst;
   logic [NR-1:0]       req_valid;
   logic [NR-1:0]       req_ready;
   logic [NR-1:0]       req_we;
   logic [NR*AW-1:0]    req_addr;
   logic [NR*MW-1:0]    req_wmask;
   logic [NR*DW-1:0]    req_wdata;
   logic                rsp_valid;
   logic [IDW-1:0]      rsp_id;
   logic [DW-1:0]       rsp_data;
   logic                rd_valid;
   logic                rd_ready;
   logic [AW-1:0]       rd_addr;
   logic                rd_rsp_valid;
   logic [DW-1:0]       rd_rsp_data;
   logic                sram_csb0;
   logic                sram_web0;
   logic [MW-1:0]       sram_wmask0;
   logic [AW-1:0]       sram_addr0;
   logic [DW-1:0]       sram_din0;
   logic [DW-1:0]       sram_dout0;
   logic                sram_csb1;
   logic [AW-1:0]       sram_addr1;
   logic [DW-1:0]       sram_dout1;

   logic [DW-1:0] mem    [1024];
   logic [DW-1:0] refmem [1024];

   bit          v  [NR];
   bit          w  [NR];
   logic [9:0]  a  [NR];
   logic [3:0]  m  [NR];
   logic [31:0] d  [NR];
   bit          rv;
   logic [9:0]  ra;

   int   ptrModel;
   int   lastWin;
   int   cyc;
   int   total;
   int   bad;
   exp_t q0[$];
   exp_t q1[$];

   sram_rw_arbiter #(.NUM_REQ(NR)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wmask    (req_wmask),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_id       (rsp_id),
      .rsp_data     (rsp_data),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .rd_addr      (rd_addr),
      .rd_rsp_valid (rd_rsp_valid),
      .rd_rsp_data  (rd_rsp_data),
      .sram_csb0    (sram_csb0),
      .sram_web0    (sram_web0),
      .sram_wmask0  (sram_wmask0),
      .sram_addr0   (sram_addr0),
      .sram_din0    (sram_din0),
      .sram_dout0   (sram_dout0),
      .sram_csb1    (sram_csb1),
      .sram_addr1   (sram_addr1),
      .sram_dout1   (sram_dout1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural macro: both ports capture on the rising edge.
   always @(posedge clk) begin
      if (!sram_csb0) begin
         if (!sram_web0) begin
            for (int b = 0; b < MW; b++) begin
               if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
            end
         end else begin
            sram_dout0 <= mem[sram_addr0];
         end
      end
      if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("[TB] FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, expv, cyc);
      end
   endtask

   // Response monitor: each expected entry must show up exactly on its due cycle.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (q0.size() > 0 && q0[0].due == cyc) begin
         e = q0.pop_front();
         checkOutput("rsp_valid", 64'(rsp_valid), 64'd1);
         checkOutput("rsp_id", 64'(rsp_id), 64'(e.id));
         checkOutput("rsp_data", 64'(rsp_data), 64'(e.data));
      end else begin
         checkOutput("rsp_valid_idle", 64'(rsp_valid), 64'd0);
      end
      if (q1.size() > 0 && q1[0].due == cyc) begin
         e = q1.pop_front();
         checkOutput("rd_rsp_valid", 64'(rd_rsp_valid), 64'd1);
         checkOutput("rd_rsp_data", 64'(rd_rsp_data), 64'(e.data));
      end else begin
         checkOutput("rd_rsp_valid_idle", 64'(rd_rsp_valid), 64'd0);
      end
   end

   task automatic driveInputs();
      for (int i = 0; i < NR; i++) begin
         req_valid[i]            = v[i];
         req_we[i]               = w[i];
         req_addr[i*AW +: AW]    = a[i];
         req_wmask[i*MW +: MW]   = m[i];
         req_wdata[i*DW +: DW]   = d[i];
      end
      rd_valid = rv;
      rd_addr  = ra;
   endtask

   // One clock of traffic: check handshakes at mid-cycle, update the model, push expectations.
   task automatic applyStimulus();
      int          expW;
      int          idx;
      bit          collide;
      logic [1:0]  expReady;
      exp_t        e;
      driveInputs();
      @(negedge clk);
      expW = -1;
      for (int k = 0; k < NR; k++) begin
         idx = (ptrModel + k) % NR;
         if (expW < 0 && v[idx]) expW = idx;
      end
      expReady = '0;
      if (expW >= 0) expReady[expW] = 1'b1;
      checkOutput("req_ready", 64'(req_ready), 64'(expReady));
      collide = 1'b0;
`ifdef SRAM_ARB_COLLISION_STALL_EN
      collide = (expW >= 0) && w[expW] && rv && (a[expW] == ra);
`endif
      checkOutput("rd_ready", 64'(rd_ready), 64'(!collide));
      if (expW < 0) begin
         checkOutput("csb0_idle", 64'(sram_csb0), 64'd1);
      end else begin
         checkOutput("csb0", 64'(sram_csb0), 64'd0);
         checkOutput("web0", 64'(sram_web0), 64'(!w[expW]));
         checkOutput("addr0", 64'(sram_addr0), 64'(a[expW]));
         checkOutput("wmask0", 64'(sram_wmask0), w[expW] ? 64'(m[expW]) : 64'hF);
      end
      if (rv && !collide) begin
         checkOutput("csb1", 64'(sram_csb1), 64'd0);
         e.id = 0; e.data = refmem[ra]; e.due = cyc + 1;
         q1.push_back(e);
         rv = 1'b0;
      end else begin
         checkOutput("csb1_idle", 64'(sram_csb1), 64'd1);
      end
      if (expW >= 0) begin
         if (w[expW]) begin
            for (int b = 0; b < MW; b++) begin
               if (m[expW][b]) refmem[a[expW]][b*8 +: 8] = d[expW][b*8 +: 8];
            end
         end else begin
            e.id = expW; e.data = refmem[a[expW]]; e.due = cyc + 1;
            q0.push_back(e);
         end
         v[expW]  = 1'b0;
         ptrModel = (expW + 1) % NR;
         lastWin  = expW;
      end
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input int id, input bit we, input logic [9:0] addr,
                        input logic [3:0] mask, input logic [31:0] data);
      v[id] = 1'b1; w[id] = we; a[id] = addr; m[id] = mask; d[id] = data;
      applyStimulus();
   endtask

   // Holds reset with requests pending so the control gating is exercised.
   task automatic doReset(input int n);
      rst = 1'b1;
      q0.delete();
      q1.delete();
      for (int i = 0; i < NR; i++) begin
         v[i] = 1'b1; w[i] = 1'b0; a[i] = '0; m[i] = '0; d[i] = '0;
      end
      rv = 1'b1; ra = '0;
      driveInputs();
      repeat (n) begin
         @(negedge clk);
         checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
         checkOutput("rst_rd_ready", 64'(rd_ready), 64'd0);
         checkOutput("rst_csb0", 64'(sram_csb0), 64'd1);
         checkOutput("rst_csb1", 64'(sram_csb1), 64'd1);
         checkOutput("rst_web0", 64'(sram_web0), 64'd1);
         checkOutput("rst_wmask0", 64'(sram_wmask0), 64'd0);
         checkOutput("rst_rsp_id", 64'(rsp_id), 64'd0);
         @(posedge clk);
         #2;
      end
      for (int i = 0; i < NR; i++) v[i] = 1'b0;
      rv       = 1'b0;
      rst      = 1'b0;
      ptrModel = 0;
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0; lastWin = -1; ptrModel = 0;
      for (int i = 0; i < 1024; i++) begin
         mem[i] = '0; refmem[i] = '0;
      end
      sram_dout0 = '0; sram_dout1 = '0;
      doReset(2);

      // Full-word write then read back
      issue(0, 1'b1, 10'h005, 4'hF, 32'hDEADBEEF);
      issue(0, 1'b0, 10'h005, 4'h0, 32'h0);
      applyStimulus();

      // Byte-masked overwrite
      issue(0, 1'b1, 10'h010, 4'hF, 32'h11223344);
      issue(1, 1'b1, 10'h010, 4'b0101, 32'hAABBCCDD);
      issue(0, 1'b0, 10'h010, 4'h0, 32'h0);
      applyStimulus();

      // Zero-mask write consumes a slot but leaves memory alone
      issue(1, 1'b1, 10'h005, 4'h0, 32'h0BADF00D);
      issue(1, 1'b0, 10'h005, 4'h0, 32'h0);
      applyStimulus();

      // Continuous contention from pointer 0
      doReset(1);
      for (int i = 0; i < 6; i++) begin
         v[0] = 1'b1; w[0] = 1'b0; a[0] = 10'h005;
         v[1] = 1'b1; w[1] = 1'b0; a[1] = 10'h010;
         applyStimulus();
         checkOutput("grant_seq", 64'(lastWin), 64'(i % 2));
      end
      applyStimulus();

      // Reset right after a read accept drops its response and clears the pointer
      issue(0, 1'b0, 10'h005, 4'h0, 32'h0);
      doReset(2);
      v[0] = 1'b1; w[0] = 1'b0; a[0] = 10'h010;
      v[1] = 1'b1; w[1] = 1'b0; a[1] = 10'h005;
      applyStimulus();
      checkOutput("ptr_after_reset", 64'(lastWin), 64'd0);
      applyStimulus();
      applyStimulus();

      // Port 1 read alongside an unrelated port-0 write
      issue(0, 1'b1, 10'h3FF, 4'hF, 32'h0000CAFE);
      rv = 1'b1; ra = 10'h3FF;
      issue(1, 1'b1, 10'h001, 4'hF, 32'h12345678);
      issue(0, 1'b0, 10'h001, 4'h0, 32'h0);
      applyStimulus();

`ifdef SRAM_ARB_COLLISION_STALL_EN
      // Same-address write/read: port 1 stalls one cycle and sees the new data
      rv = 1'b1; ra = 10'h020;
      issue(0, 1'b1, 10'h020, 4'hF, 32'h00000042);
      checkOutput("stall_pending", 64'(rv), 64'd1);
      applyStimulus();
      applyStimulus();
`else
      rv = 1'b1; ra = 10'h021;
      issue(0, 1'b1, 10'h020, 4'hF, 32'h00000042);
      applyStimulus();
`endif

      repeat (3) applyStimulus();
      checkOutput("q0_drained", 64'(q0.size()), 64'd0);
      checkOutput("q1_drained", 64'(q1.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
